// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the 8-to-3 priority encoder.
package priority_encoder_pkg;

    localparam int N  = 8;
    localparam int CW = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    function automatic logic [N-1:0] code_onehot(input logic [CW-1:0] c);
        logic [N-1:0] m;
        m = '0;
        m[c] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/priority_encoder_8to3_pri_find8.sv
// Combinational finder over an 8-bit vector starting at a given index.
// Searches downward by default, upward when PRIORITY_ENCODER_RR_EN is defined.
module pri_find8
    import priority_encoder_pkg::*;
(
    input  logic [N-1:0]  vec,
    input  logic [CW-1:0] start,
    output logic [CW-1:0] idx,
    output logic          found
);

    logic [CW-1:0] k;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef PRIORITY_ENCODER_RR_EN
            k = start + CW'(i);
`else
            k = start - CW'(i);
`endif
            if (!found && vec[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_8to3.sv
// Sticky-pending 8-to-3 priority encoder with valid/ready code output.
// Define PRIORITY_ENCODER_RR_EN for round-robin instead of fixed priority.
module priority_encoder_8to3
    import priority_encoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [CW-1:0] code,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  pend,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [CW-1:0] code_q, code_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  pend_q, pend_d;

    logic          hs;
    logic [N-1:0]  clr_mask;
    logic [N-1:0]  rem;
    logic [CW-1:0] start;
    logic [CW-1:0] win_idx;
    logic          win_found;

    assign hs       = valid_q && ready;
    assign clr_mask = hs ? code_onehot(code_q) : '0;
    // In IDLE clr_mask is zero, so rem is simply pend and one finder serves both states.
    assign rem      = pend_q & ~clr_mask;
    assign pend_d   = rem | (en ? req : '0);

`ifdef PRIORITY_ENCODER_RR_EN
    logic [CW-1:0] last_q, last_d;

    assign last_d = hs ? code_q : last_q;
    assign start  = last_d + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) last_q <= '1;
        else     last_q <= last_d;
    end
`else
    assign start = '1;
`endif

    pri_find8 u_find (
        .vec   (rem),
        .start (start),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    code_d  = win_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (win_found) begin
                        code_d = win_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign pend  = pend_q;
    assign busy  = (pend_q != '0) || valid_q;

endmodule
